// File: rtl/lsu_sb.sv
`default_nettype none
// ============================================================================
// Module   : lsu_sb
// Purpose  : Load/store unit with an in-order retiring store buffer sharing a
//            single-outstanding data-cache port with a blocking load path.
// Revision : 1.0 - initial release
// ============================================================================
module lsu_sb #(
  parameter int SB_DEPTH = 4,
  parameter int ROB_AW   = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              flush,
  input  logic              issue_valid,
  output logic              issue_ready,
  input  logic [3:0]        issue_op,
  input  logic [31:0]       issue_base,
  input  logic [31:0]       issue_off,
  input  logic [31:0]       issue_wdata,
  input  logic [ROB_AW-1:0] issue_rob,
  input  logic              store_retire,
  output logic              cm_valid,
  output logic [ROB_AW-1:0] cm_rob,
  output logic [31:0]       cm_data,
  output logic [31:0]       cm_addr,
  output logic              cm_exc_load,
  output logic              cm_exc_store,
  output logic              d_req,
  output logic              d_wr,
  output logic [1:0]        d_size,
  output logic [31:0]       d_addr,
  output logic [31:0]       d_wdata,
  output logic [3:0]        d_strb,
  input  logic              d_addr_ok,
  input  logic              d_data_ok,
  input  logic [31:0]       d_rdata,
  output logic              sb_empty
);

  localparam int            c_iw    = $clog2(SB_DEPTH);
  localparam logic [c_iw:0] c_depth = (c_iw+1)'(SB_DEPTH);

  localparam logic [3:0] c_op_lb  = 4'd0;
  localparam logic [3:0] c_op_lbu = 4'd1;
  localparam logic [3:0] c_op_lh  = 4'd2;
  localparam logic [3:0] c_op_lhu = 4'd3;
  localparam logic [3:0] c_op_lw  = 4'd4;
  localparam logic [3:0] c_op_sb  = 4'd8;
  localparam logic [3:0] c_op_sh  = 4'd9;
  localparam logic [3:0] c_op_sw  = 4'd10;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHK   = 3'd1,
    ST_REQ   = 3'd2,
    ST_WAIT  = 3'd3,
    ST_DRAIN = 3'd4
  } ld_state_t;

  ld_state_t         r_state;
  logic [c_iw:0]     r_head, r_ret, r_tail;
  logic              r_live;
  logic              r_st_out;
  logic [31:0]       r_ld_addr;
  logic [3:0]        r_ld_op;
  logic [ROB_AW-1:0] r_ld_rob;

  logic              r_cm_valid, r_cm_exc_load, r_cm_exc_store;
  logic [ROB_AW-1:0] r_cm_rob;
  logic [31:0]       r_cm_data, r_cm_addr;
  logic              r_d_req, r_d_wr;
  logic [1:0]        r_d_size;
  logic [31:0]       r_d_addr, r_d_wdata;
  logic [3:0]        r_d_strb;

  logic [31:0] r_sb_addr [SB_DEPTH];
  logic [31:0] r_sb_data [SB_DEPTH];
  logic [3:0]  r_sb_strb [SB_DEPTH];
  logic [1:0]  r_sb_size [SB_DEPTH];

  logic [31:0]     w_addr;
  logic            w_is_load, w_is_store, w_mis, w_accept, w_enq;
  logic [c_iw:0]   w_count, w_ret_nx;
  logic            w_full, w_ret_pend, w_unret, w_match;
  logic [c_iw-1:0] w_head_idx;
  logic [c_iw-1:0] w_slot_off [SB_DEPTH];
  logic [31:0]     w_st_data;
  logic [3:0]      w_st_strb;

  function automatic logic [31:0] f_ld_ext(input logic [31:0] rd, input logic [1:0] a,
                                           input logic [3:0] op);
    logic [31:0] sh;
    sh = rd >> {a, 3'b000};
    case (op)
      c_op_lb:  f_ld_ext = {{24{sh[7]}}, sh[7:0]};
      c_op_lbu: f_ld_ext = {24'd0, sh[7:0]};
      c_op_lh:  f_ld_ext = {{16{sh[15]}}, sh[15:0]};
      c_op_lhu: f_ld_ext = {16'd0, sh[15:0]};
      default:  f_ld_ext = rd;
    endcase
  endfunction

  assign w_addr     = issue_base + issue_off;
  assign w_is_load  = issue_op inside {c_op_lb, c_op_lbu, c_op_lh, c_op_lhu, c_op_lw};
  assign w_is_store = issue_op inside {c_op_sb, c_op_sh, c_op_sw};
  assign w_count    = r_tail - r_head;
  assign w_full     = (w_count == c_depth);
  assign w_ret_pend = (r_head != r_ret);
  assign w_unret    = (r_ret != r_tail);
  assign w_ret_nx   = (store_retire && w_unret) ? r_ret + 1'b1 : r_ret;
  assign w_head_idx = r_head[c_iw-1:0];
  // A same-cycle flush squashes the offered instruction as younger state.
  assign w_accept   = issue_valid && issue_ready && !flush;
  assign w_enq      = w_accept && w_is_store && !w_mis;

  always_comb begin
    w_mis = 1'b0;
    case (issue_op)
      c_op_lw, c_op_sw:           w_mis = |w_addr[1:0];
      c_op_lh, c_op_lhu, c_op_sh: w_mis = w_addr[0];
      default: ;
    endcase
  end

  always_comb begin
    w_st_data = issue_wdata;
    w_st_strb = 4'b1111;
    case (issue_op)
      c_op_sb: begin
        w_st_data = {24'd0, issue_wdata[7:0]} << {w_addr[1:0], 3'b000};
        w_st_strb = 4'b0001 << w_addr[1:0];
      end
      c_op_sh: begin
        w_st_data = w_addr[1] ? {issue_wdata[15:0], 16'd0} : {16'd0, issue_wdata[15:0]};
        w_st_strb = w_addr[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end

  // Word-granular hazard check against every live entry, retired or not.
  always_comb begin
    w_match = 1'b0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      w_slot_off[i] = c_iw'(i) - w_head_idx;
      if (({1'b0, w_slot_off[i]} < w_count) && (r_sb_addr[i][31:2] == r_ld_addr[31:2]))
        w_match = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_sb_addr[r_tail[c_iw-1:0]] <= w_addr;
      r_sb_data[r_tail[c_iw-1:0]] <= w_st_data;
      r_sb_strb[r_tail[c_iw-1:0]] <= w_st_strb;
      r_sb_size[r_tail[c_iw-1:0]] <= issue_op[1:0];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_head         <= '0;
      r_ret          <= '0;
      r_tail         <= '0;
      r_state        <= ST_IDLE;
      r_live         <= 1'b0;
      r_st_out       <= 1'b0;
      r_ld_addr      <= '0;
      r_ld_op        <= '0;
      r_ld_rob       <= '0;
      r_cm_valid     <= 1'b0;
      r_cm_rob       <= '0;
      r_cm_data      <= '0;
      r_cm_addr      <= '0;
      r_cm_exc_load  <= 1'b0;
      r_cm_exc_store <= 1'b0;
      r_d_req        <= 1'b0;
      r_d_wr         <= 1'b0;
      r_d_size       <= '0;
      r_d_addr       <= '0;
      r_d_wdata      <= '0;
      r_d_strb       <= '0;
    end else begin
      r_live         <= 1'b1;
      r_cm_valid     <= 1'b0;
      r_cm_exc_load  <= 1'b0;
      r_cm_exc_store <= 1'b0;

      // Retire is applied before the flush truncation.
      r_ret <= w_ret_nx;
      if (flush)
        r_tail <= w_ret_nx;
      else if (w_enq)
        r_tail <= r_tail + 1'b1;

      if (w_accept) begin
        if (w_mis) begin
          r_cm_valid     <= 1'b1;
          r_cm_rob       <= issue_rob;
          r_cm_addr      <= w_addr;
          r_cm_data      <= '0;
          r_cm_exc_load  <= w_is_load;
          r_cm_exc_store <= w_is_store;
        end else if (w_is_store) begin
          r_cm_valid <= 1'b1;
          r_cm_rob   <= issue_rob;
          r_cm_addr  <= w_addr;
          r_cm_data  <= w_st_data;
        end else if (w_is_load) begin
          r_ld_addr <= w_addr;
          r_ld_op   <= issue_op;
          r_ld_rob  <= issue_rob;
          r_state   <= ST_CHK;
        end
      end

      if (r_st_out) begin
        if (r_d_req) begin
          if (d_addr_ok) r_d_req <= 1'b0;
        end else if (d_data_ok) begin
          r_st_out <= 1'b0;
          r_head   <= r_head + 1'b1;
        end
      end else if (w_ret_pend && !r_d_req && r_state != ST_WAIT && r_state != ST_DRAIN) begin
        r_st_out  <= 1'b1;
        r_d_req   <= 1'b1;
        r_d_wr    <= 1'b1;
        r_d_addr  <= r_sb_addr[w_head_idx];
        r_d_wdata <= r_sb_data[w_head_idx];
        r_d_strb  <= r_sb_strb[w_head_idx];
        r_d_size  <= r_sb_size[w_head_idx];
      end

      case (r_state)
        ST_IDLE: ;
        ST_CHK: begin
          if (flush)         r_state <= ST_IDLE;
          else if (!w_match) r_state <= ST_REQ;
        end
        ST_REQ: begin
          if (r_d_req && !r_d_wr) begin
            if (d_addr_ok) begin
              r_d_req <= 1'b0;
              r_state <= flush ? ST_DRAIN : ST_WAIT;
            end else if (flush || w_ret_pend) begin
              // Unhandshaken load yields to a retired store or a flush.
              r_d_req <= 1'b0;
              if (flush) r_state <= ST_IDLE;
            end
          end else if (flush) begin
            r_state <= ST_IDLE;
          end else if (!r_st_out && !w_ret_pend) begin
            r_d_req   <= 1'b1;
            r_d_wr    <= 1'b0;
            r_d_addr  <= r_ld_addr;
            r_d_size  <= r_ld_op[2:1];
            r_d_strb  <= 4'b0000;
            r_d_wdata <= '0;
          end
        end
        ST_WAIT: begin
          if (d_data_ok) begin
            r_state <= ST_IDLE;
            if (!flush) begin
              r_cm_valid <= 1'b1;
              r_cm_rob   <= r_ld_rob;
              r_cm_addr  <= r_ld_addr;
              r_cm_data  <= f_ld_ext(d_rdata, r_ld_addr[1:0], r_ld_op);
            end
          end else if (flush) begin
            r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (d_data_ok) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign issue_ready  = r_live && (r_state == ST_IDLE) && !w_full;
  assign sb_empty     = (r_head == r_tail);
  assign cm_valid     = r_cm_valid;
  assign cm_rob       = r_cm_rob;
  assign cm_data      = r_cm_data;
  assign cm_addr      = r_cm_addr;
  assign cm_exc_load  = r_cm_exc_load;
  assign cm_exc_store = r_cm_exc_store;
  assign d_req        = r_d_req;
  assign d_wr         = r_d_wr;
  assign d_size       = r_d_size;
  assign d_addr       = r_d_addr;
  assign d_wdata      = r_d_wdata;
  assign d_strb       = r_d_strb;

endmodule
`default_nettype wire

// File: tb/tb_lsu_sb.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsu_sb
// Purpose  : Directed self-checking bench for lsu_sb with a simple cache model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lsu_sb;

  logic        clk = 1'b0;
  logic        resetn, flush, issue_valid, store_retire;
  logic        issue_ready;
  logic [3:0]  issue_op;
  logic [31:0] issue_base, issue_off, issue_wdata;
  logic [3:0]  issue_rob;
  logic        cm_valid, cm_exc_load, cm_exc_store;
  logic [3:0]  cm_rob;
  logic [31:0] cm_data, cm_addr;
  logic        d_req, d_wr;
  logic [1:0]  d_size;
  logic [31:0] d_addr, d_wdata;
  logic [3:0]  d_strb;
  logic        d_addr_ok = 1'b0;
  logic        d_data_ok = 1'b0;
  logic [31:0] d_rdata;
  logic        sb_empty;

  int n_pass  = 0;
  int n_total = 0;

  int          lat   = 2;
  bit          busy  = 1'b0;
  int          cnt   = 0;
  int          n_wr  = 0;
  int          n_rd  = 0;
  int          n_cm  = 0;
  logic [31:0] last_waddr = '0;

  localparam logic [3:0] LB = 4'd0, LBU = 4'd1, LH = 4'd2, LHU = 4'd3, LW = 4'd4;
  localparam logic [3:0] SB = 4'd8, SH = 4'd9, SW = 4'd10;

  lsu_sb #(.SB_DEPTH(4), .ROB_AW(4)) dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_op(issue_op),
    .issue_base(issue_base), .issue_off(issue_off), .issue_wdata(issue_wdata),
    .issue_rob(issue_rob), .store_retire(store_retire),
    .cm_valid(cm_valid), .cm_rob(cm_rob), .cm_data(cm_data), .cm_addr(cm_addr),
    .cm_exc_load(cm_exc_load), .cm_exc_store(cm_exc_store),
    .d_req(d_req), .d_wr(d_wr), .d_size(d_size), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_strb(d_strb), .d_addr_ok(d_addr_ok),
    .d_data_ok(d_data_ok), .d_rdata(d_rdata), .sb_empty(sb_empty)
  );

  always #5 clk = ~clk;

  // Cache model: accepts a request immediately, answers lat+1 cycles later.
  always @(negedge clk) begin
    d_addr_ok = 1'b0;
    d_data_ok = 1'b0;
    if (cm_valid === 1'b1) n_cm++;
    if (busy) begin
      if (cnt == 0) begin
        d_data_ok = 1'b1;
        busy      = 1'b0;
      end else begin
        cnt--;
      end
    end else if (d_req === 1'b1) begin
      d_addr_ok = 1'b1;
      busy      = 1'b1;
      cnt       = lat;
      if (d_wr) begin
        n_wr++;
        last_waddr = d_addr;
      end else begin
        n_rd++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  function automatic bit cond(input int which);
    case (which)
      0:       return d_req === 1'b1;
      1:       return cm_valid === 1'b1;
      2:       return sb_empty === 1'b1;
      3:       return issue_ready === 1'b1;
      4:       return (d_req === 1'b1) && (d_wr === 1'b0);
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_cond(input int which, input int max, input string tag);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < max && !hit; i++) begin
      hit = cond(which);
      if (!hit) tick();
    end
    chk(tag, {31'd0, hit}, 32'd1);
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] base, input logic [31:0] off,
                       input logic [31:0] wdata, input logic [3:0] rob);
    wait_cond(3, 50, "issue_ready_wait");
    issue_valid = 1'b1;
    issue_op    = op;
    issue_base  = base;
    issue_off   = off;
    issue_wdata = wdata;
    issue_rob   = rob;
    tick();
    issue_valid = 1'b0;
  endtask

  task automatic retire_pulse();
    store_retire = 1'b1;
    tick();
    store_retire = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int b_rd, b_wr, b_cm;
    resetn = 1'b0; flush = 1'b0; issue_valid = 1'b0; store_retire = 1'b0;
    issue_op = '0; issue_base = '0; issue_off = '0; issue_wdata = '0; issue_rob = '0;
    d_rdata = '0;
    repeat (2) tick();
    chk("rst_issue_ready", {31'd0, issue_ready}, 32'd0);
    chk("rst_sb_empty",    {31'd0, sb_empty},    32'd1);
    chk("rst_d_req",       {31'd0, d_req},       32'd0);
    chk("rst_cm_valid",    {31'd0, cm_valid},    32'd0);
    chk("rst_d_addr",      d_addr,               32'd0);
    resetn = 1'b1;
    tick();
    tick();
    chk("post_rst_ready", {31'd0, issue_ready}, 32'd1);

    // LB 0x103 -> byte 3 of 0x80FF0000, sign-extended
    d_rdata = 32'h80FF_0000;
    issue(LB, 32'h100, 32'd3, 32'd0, 4'd1);
    wait_cond(0, 20, "lb_dreq_wait");
    chk("lb_d_addr", d_addr, 32'h103);
    chk("lb_d_size", {30'd0, d_size}, 32'd0);
    chk("lb_d_wr",   {31'd0, d_wr},   32'd0);
    wait_cond(1, 20, "lb_cm_wait");
    chk("lb_cm_data", cm_data, 32'hFFFF_FF80);
    chk("lb_cm_rob",  {28'd0, cm_rob}, 32'd1);
    chk("lb_cm_addr", cm_addr, 32'h103);
    chk("lb_exc",     {31'd0, cm_exc_load}, 32'd0);
    tick();
    chk("cm_one_cycle", {31'd0, cm_valid}, 32'd0);

    // LHU upper half, LH lower half sign-extended, LBU byte 1
    d_rdata = 32'h80FF_1234;
    issue(LHU, 32'h100, 32'd2, 32'd0, 4'd2);
    wait_cond(0, 20, "lhu_dreq_wait");
    chk("lhu_d_size", {30'd0, d_size}, 32'd1);
    wait_cond(1, 20, "lhu_cm_wait");
    chk("lhu_cm_data", cm_data, 32'h0000_80FF);
    d_rdata = 32'h1234_F00D;
    issue(LH, 32'h100, 32'd0, 32'd0, 4'd3);
    wait_cond(1, 30, "lh_cm_wait");
    chk("lh_cm_data", cm_data, 32'hFFFF_F00D);
    d_rdata = 32'h80FF_7F00;
    issue(LBU, 32'h0FF, 32'd2, 32'd0, 4'd4);
    wait_cond(1, 30, "lbu_cm_wait");
    chk("lbu_cm_data", cm_data, 32'h0000_007F);

    // SH 0x202 0x1234: shifted commit, then drain with upper strobes
    issue(SH, 32'h200, 32'd2, 32'h0000_1234, 4'd5);
    chk("sh_cm_valid", {31'd0, cm_valid}, 32'd1);
    chk("sh_cm_data",  cm_data, 32'h1234_0000);
    chk("sh_cm_rob",   {28'd0, cm_rob}, 32'd5);
    chk("sh_exc",      {31'd0, cm_exc_store}, 32'd0);
    tick();
    chk("sh_no_drain_unretired", {31'd0, d_req}, 32'd0);
    chk("sh_sb_not_empty", {31'd0, sb_empty}, 32'd0);
    retire_pulse();
    wait_cond(0, 20, "sh_dreq_wait");
    chk("sh_d_wr",    {31'd0, d_wr}, 32'd1);
    chk("sh_d_strb",  {28'd0, d_strb}, 32'hC);
    chk("sh_d_wdata", d_wdata, 32'h1234_0000);
    chk("sh_d_addr",  d_addr, 32'h202);
    chk("sh_d_size",  {30'd0, d_size}, 32'd1);
    wait_cond(2, 30, "sh_drained");

    // SB 0x105 0x55AA
    issue(SB, 32'h104, 32'd1, 32'h0000_55AA, 4'd6);
    chk("sb_cm_data", cm_data, 32'h0000_AA00);
    retire_pulse();
    wait_cond(0, 20, "sb_dreq_wait");
    chk("sb_d_strb", {28'd0, d_strb}, 32'h2);
    wait_cond(2, 30, "sb_drained");

    // Misaligned LW 0x13 and SW 0x22
    b_rd = n_rd;
    issue(LW, 32'h10, 32'd3, 32'd0, 4'd7);
    chk("lw_mis_cm_valid", {31'd0, cm_valid}, 32'd1);
    chk("lw_mis_exc_load", {31'd0, cm_exc_load}, 32'd1);
    chk("lw_mis_cm_data",  cm_data, 32'd0);
    chk("lw_mis_cm_rob",   {28'd0, cm_rob}, 32'd7);
    repeat (4) tick();
    chk("lw_mis_no_read", n_rd, b_rd);
    issue(SW, 32'h20, 32'd2, 32'hFFFF_FFFF, 4'd8);
    chk("sw_mis_exc_store", {31'd0, cm_exc_store}, 32'd1);
    chk("sw_mis_cm_data",   cm_data, 32'd0);
    tick();
    chk("sw_mis_no_entry", {31'd0, sb_empty}, 32'd1);

    // SW 0x40 unretired blocks LW 0x40 in CHK until it drains
    d_rdata = 32'hCAFE_F00D;
    issue(SW, 32'h40, 32'd0, 32'hDEAD_BEEF, 4'd9);
    b_rd = n_rd;
    b_wr = n_wr;
    issue(LW, 32'h40, 32'd0, 32'd0, 4'd10);
    repeat (5) tick();
    chk("hzd_no_dreq",   {31'd0, d_req}, 32'd0);
    chk("hzd_not_ready", {31'd0, issue_ready}, 32'd0);
    chk("hzd_no_read",   n_rd, b_rd);
    retire_pulse();
    wait_cond(0, 20, "hzd_store_wait");
    chk("hzd_store_first", {31'd0, d_wr}, 32'd1);
    wait_cond(4, 40, "hzd_load_wait");
    chk("hzd_store_done", n_wr, b_wr + 1);
    chk("hzd_load_addr",  d_addr, 32'h40);
    chk("hzd_sb_empty",   {31'd0, sb_empty}, 32'd1);
    wait_cond(1, 30, "hzd_cm_wait");
    chk("hzd_cm_data", cm_data, 32'hCAFE_F00D);

    // Fill the buffer, then free one slot by retiring and draining
    for (int i = 0; i < 4; i++)
      issue(SW, 32'h300, 32'(4 * i), 32'(i), 4'(i));
    chk("full_not_ready", {31'd0, issue_ready}, 32'd0);
    b_wr = n_wr;
    retire_pulse();
    wait_cond(3, 30, "full_ready_back");
    chk("full_one_written", n_wr, b_wr + 1);
    chk("full_last_waddr",  last_waddr, 32'h300);

    // Flush drops the three unretired stores
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_sb_empty", {31'd0, sb_empty}, 32'd1);
    repeat (6) tick();
    chk("flush_no_write", n_wr, b_wr + 1);

    // Flush during load WAIT with two retired and one unretired store
    issue(SW, 32'h500, 32'd0, 32'h11, 4'd1);
    issue(SW, 32'h504, 32'd0, 32'h22, 4'd2);
    issue(SW, 32'h508, 32'd0, 32'h33, 4'd3);
    lat  = 8;
    issue(LW, 32'h600, 32'd0, 32'd0, 4'd4);
    wait_cond(4, 20, "fw_load_wait");
    tick();
    b_wr = n_wr;
    b_cm = n_cm;
    retire_pulse();
    store_retire = 1'b1;
    flush        = 1'b1;
    tick();
    store_retire = 1'b0;
    flush        = 1'b0;
    wait_cond(2, 80, "fw_drained");
    repeat (4) tick();
    chk("fw_two_written", n_wr, b_wr + 2);
    chk("fw_last_waddr",  last_waddr, 32'h504);
    chk("fw_no_commit",   n_cm, b_cm);
    chk("fw_sb_empty",    {31'd0, sb_empty}, 32'd1);
    chk("fw_ready",       {31'd0, issue_ready}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lsu_sb.md
LSU_SB -- requirements
Module: lsu_sb

Interface
REQ-001 Parameters SHALL be (name, default, meaning): SB_DEPTH, 4, store-buffer entries (power of 2, >=2); ROB_AW, 4, ROB index width.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk  in  1  clock
- resetn  in  1  reset; one clock; reset is asynchronous and active-low
- flush  in  1  squash all speculative state
- issue_valid  in  1  instruction offered
- issue_ready  out  1  instruction accepted when valid&ready
- issue_op  in  4  LB=0 LBU=1 LH=2 LHU=3 LW=4 SB=8 SH=9 SW=10
- issue_base, issue_off  in  32  address operands
- issue_wdata  in  32  store data (unshifted)
- issue_rob  in  ROB_AW  destination ROB index
- store_retire  in  1  ROB retired the oldest store
- cm_valid  out  1  commit pulse
- cm_rob  out  ROB_AW  committed ROB index
- cm_data, cm_addr  out  32  load result or shifted store data; effective address
- cm_exc_load, cm_exc_store  out  1  misaligned load / store
- d_req, d_wr  out  1  cache request; write
- d_size  out  2  0=byte 1=half 2=word
- d_addr, d_wdata  out  32  cache address; write data
- d_strb  out  4  byte enables
- d_addr_ok, d_data_ok  in  1  address accepted; data returned/write done
- d_rdata  in  32  read data
- sb_empty  out  1  no valid store-buffer entries

Function
REQ-003 Address SHALL be issue_base+issue_off modulo 2^32.
REQ-004 Misalignment SHALL be: LW/SW with addr[1:0]!=0; LH/LHU/SH with addr[0]!=0; such ops generate no cache access and no buffer entry.
REQ-005 issue_ready SHALL be 1 only when the load FSM is IDLE and the store buffer is not full.
REQ-006 Load FSM states SHALL be IDLE, CHK, REQ, WAIT, DRAIN; accepted aligned load: IDLE->CHK.
REQ-007 CHK SHALL stay while any valid buffer entry matches addr[31:2], else go to REQ.
REQ-008 REQ SHALL assert d_req (d_wr=0) only when no store transaction is outstanding and no committed store is waiting; on d_addr_ok go to WAIT.
REQ-009 WAIT on d_data_ok SHALL go to IDLE and register cm_* next cycle with byte/half extracted by addr[1:0], sign- or zero-extended per op.
REQ-010 Stores SHALL shift data and set d_strb per addr (SB: strb=1<<addr[1:0]; SH: 0011/1100; SW: 1111), enqueue at tail, and commit (cm_data=shifted data) one cycle after acceptance.
REQ-011 Misaligned ops SHALL commit one cycle after acceptance with the corresponding exception flag and cm_data=0.
REQ-012 Buffer SHALL keep head, retire and tail pointers with wrap bit; store_retire advances retire pointer; store_retire with no unretired entry SHALL be ignored.
REQ-013 Retired entries SHALL drain in order from head: d_req with d_wr=1 until d_addr_ok, then wait d_data_ok, then pop; only one cache transaction (load or store) outstanding at any time; retired store drain has priority over a load not yet handshaken.
REQ-014 Flush SHALL set tail to retire pointer, discard any pending commit, and return CHK/REQ to IDLE; WAIT SHALL go to DRAIN, which absorbs d_data_ok without commit, then IDLE; retired entries keep draining.
REQ-015 Same-cycle store_retire and flush SHALL retire first, then truncate.
REQ-016 Same-cycle enqueue and pop at full SHALL not occur (ready low); at non-full both SHALL apply.
REQ-017 cm_valid SHALL be a single-cycle pulse with no backpressure.

Reset
REQ-018 On resetn low all pointers, FSM (IDLE), cm_*, d_req, d_wr, d_size, d_addr, d_wdata, d_strb SHALL be 0; sb_empty=1, issue_ready=0 during reset.

Verification
REQ-019 LB base=0x100 off=3, d_rdata=0x80FF_0000 -> d_addr=0x103, size=0; cm_data=0xFFFF_FF80.
REQ-020 SH addr 0x202 data 0x1234 -> cm_data=0x1234_0000; after store_retire d_wr=1, d_strb=1100.
REQ-021 LW addr 0x13 -> cm_exc_load=1 one cycle later, d_req never asserted.
REQ-022 SW 0x40 queued unretired, LW 0x40 -> CHK holds; store_retire -> store drains, then load issues.
REQ-023 Fill SB_DEPTH stores -> issue_ready=0; retire and drain one -> issue_ready=1.
REQ-024 Flush during load WAIT with 2 retired + 1 unretired entries -> no load commit, 2 stores written, sb_empty=1.
